// File: rtl/cache_axi_pkg.sv
// Shared encodings, AXI constants and FSM state types for the cache-to-AXI bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_axi_pkg;

    // Cache request type encodings (rd_type / wr_type)
    localparam logic [2:0] TYPE_BYTE = 3'd0;
    localparam logic [2:0] TYPE_HALF = 3'd1;
    localparam logic [2:0] TYPE_WORD = 3'd2;
    localparam logic [2:0] TYPE_LINE = 3'd4;

    // AXI constants
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam int         LINE_BEATS     = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_RESP
    } wr_state_e;

    // A line is one INCR burst of LINE_BEATS words; anything else is a single beat.
    function automatic logic [7:0] axi_len(input logic [2:0] req_type);
        return (req_type == TYPE_LINE) ? 8'(LINE_BEATS - 1) : 8'd0;
    endfunction

    // Byte/half keep their natural size; word and line both move 4-byte beats.
    function automatic logic [2:0] axi_size(input logic [2:0] req_type);
        case (req_type)
            TYPE_BYTE: return 3'd0;
            TYPE_HALF: return 3'd1;
            TYPE_WORD: return AXI_SIZE_4B;
            default:   return AXI_SIZE_4B;
        endcase
    endfunction

endpackage

// File: rtl/axi_wr_burst.sv
// Write buffer + AW/W/B sequencing for one outstanding cache write-back.
// Latency: awvalid the cycle after acceptance, W beats follow the AW handshake, B closes it.
// Backpressure: wr_rdy low while busy; each beat holds until wready, buffer holds until bvalid.
module axi_wr_burst
    import cache_axi_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int WR_ID = 1
) (
    input  logic            clk,
    input  logic            reset,
    // cache side
    input  logic            wr_req,
    input  logic [2:0]      wr_type,
    input  logic [31:0]     wr_addr,
    input  logic [3:0]      wr_wstrb,
    input  logic [127:0]    wr_data,
    output logic            wr_rdy,
    // hazard view for the read side
    output logic            busy,
    output logic [27:0]     line_addr,
    // AXI AW
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    // AXI W
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI B
    input  logic            bvalid,
    output logic            bready
);

    wr_state_e      state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     type_q, type_d;
    logic [3:0]     strb_q, strb_d;
    logic [127:0]   data_q, data_d;
    logic [1:0]     cnt_q, cnt_d;

    // State and buffer registers; reset drops every valid at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= W_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            strb_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: AW handshake, then beats until the last one is taken, then wait for B
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:  if (wr_req)            state_d = W_AW;
            W_AW:    if (awready)           state_d = W_DATA;
            W_DATA:  if (wready && wlast)   state_d = W_RESP;
            W_RESP:  if (bvalid)            state_d = W_IDLE;
            default:                        state_d = W_IDLE;
        endcase
    end

    // Buffer capture only when idle (a wr_req while busy is dropped); beat counter
    always_comb begin
        addr_d = addr_q;
        type_d = type_q;
        strb_d = strb_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (state_q == W_IDLE && wr_req) begin
            addr_d = wr_addr;
            type_d = wr_type;
            strb_d = (wr_type == TYPE_LINE) ? 4'hf : wr_wstrb;
            data_d = wr_data;
        end
        if (state_q == W_AW && awready) begin
            cnt_d = '0;
        end else if (state_q == W_DATA && wready) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Channel outputs decoded from state; fields come straight from the buffer so they
    // cannot move while a valid is up
    always_comb begin
        wr_rdy    = (state_q == W_IDLE);
        busy      = (state_q != W_IDLE);
        line_addr = addr_q[31:4];
        awid      = ID_W'(WR_ID);
        awaddr    = addr_q;
        awlen     = axi_len(type_q);
        awsize    = axi_size(type_q);
        awburst   = AXI_BURST_INCR;
        awvalid   = (state_q == W_AW);
        wdata     = data_q[32*cnt_q +: 32];
        wstrb     = strb_q;
        wlast     = (state_q == W_DATA) && ({6'd0, cnt_q} == awlen);
        wvalid    = (state_q == W_DATA);
        bready    = (state_q == W_RESP);
    end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache miss/write-back port to AXI4 master; one read and one write outstanding.
// Latency: arvalid/awvalid the cycle after acceptance; read data passes through with zero delay.
// Backpressure: rd_rdy low while a read is in flight or the read hits the line being written back.
module cache_axi_bridge
    import cache_axi_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int RD_ID = 0,
    parameter int WR_ID = 1
) (
    input  logic            clk,
    input  logic            reset,
    // cache read
    input  logic            rd_req,
    input  logic [2:0]      rd_type,
    input  logic [31:0]     rd_addr,
    output logic            rd_rdy,
    output logic            ret_valid,
    output logic            ret_last,
    output logic [31:0]     ret_data,
    // cache write
    input  logic            wr_req,
    input  logic [2:0]      wr_type,
    input  logic [31:0]     wr_addr,
    input  logic [3:0]      wr_wstrb,
    input  logic [127:0]    wr_data,
    output logic            wr_rdy,
    // AXI AR
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    // AXI R
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AXI AW
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    // AXI W
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI B
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    rd_state_e      rd_state_q, rd_state_d;
    logic [31:0]    raddr_q, raddr_d;
    logic [2:0]     rtype_q, rtype_d;

    logic           wr_busy;
    logic [27:0]    wr_line_addr;
    logic           hazard;

    // Response IDs and error codes are not acted on by this bridge
    logic           unused_resp;
    assign unused_resp = ^{rid, rresp, bid, bresp};

    // A read may not overtake a write to the same line, whether buffered or arriving now
    assign hazard = (wr_busy && (rd_addr[31:4] == wr_line_addr)) ||
                    (wr_req  && (rd_addr[31:4] == wr_addr[31:4]));

    // Read state and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            raddr_q    <= '0;
            rtype_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            raddr_q    <= raddr_d;
            rtype_q    <= rtype_d;
        end
    end

    // Read next-state and request capture
    always_comb begin
        rd_state_d = rd_state_q;
        raddr_d    = raddr_q;
        rtype_d    = rtype_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_req && !hazard) begin
                    rd_state_d = R_AR;
                    raddr_d    = rd_addr;
                    rtype_d    = rd_type;
                end
            end
            R_AR:    if (arready)           rd_state_d = R_DATA;
            R_DATA:  if (rvalid && rlast)   rd_state_d = R_IDLE;
            default:                        rd_state_d = R_IDLE;
        endcase
    end

    // Read outputs; R beats are forwarded combinationally while in R_DATA
    always_comb begin
        rd_rdy    = (rd_state_q == R_IDLE) && !hazard;
        arid      = ID_W'(RD_ID);
        araddr    = raddr_q;
        arlen     = axi_len(rtype_q);
        arsize    = axi_size(rtype_q);
        arburst   = AXI_BURST_INCR;
        arvalid   = (rd_state_q == R_AR);
        rready    = (rd_state_q == R_DATA);
        ret_valid = (rd_state_q == R_DATA) && rvalid;
        ret_last  = (rd_state_q == R_DATA) && rlast;
        ret_data  = rdata;
    end

    axi_wr_burst #(
        .ID_W  (ID_W),
        .WR_ID (WR_ID)
    ) u_wr (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .busy      (wr_busy),
        .line_addr (wr_line_addr),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready)
    );

endmodule
